// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipe: forwarding, load-use, branch flush, memory-wait hold.
// Optional perf counters (stall_cycles, flush_events) are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] Rs1E,
  input  logic [REG_ADDR_W-1:0] Rs2E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic                  ResultSrcE,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  PCSrcE,
  input  logic                  MemReqM,
  input  logic                  MemReadyM,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushW,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events
`endif
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, TIMEOUT} state_e;

  // Wait counter only needs to reach MEM_TIMEOUT-1; with the watchdog off it simply saturates.
  localparam int WCNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_MAX   = (MEM_TIMEOUT == 0) ? {WCNT_W{1'b1}}
                                                                : WCNT_W'(MEM_TIMEOUT - 1);
  localparam logic [WCNT_W-1:0] WCNT_ENTRY = (WCNT_MAX == '0) ? '0 : WCNT_W'(1);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("hazard_ctrl: CNT_W must be at least 1");
  end

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_busy, load_use, hold_pipe, run_rules, branch_flush;
  logic              fwd_m_a, fwd_w_a, fwd_m_b, fwd_w_b;

  assign mem_busy = MemReqM & ~MemReadyM;
  assign load_use = ResultSrcE & (RdE != '0) & ((RdE == Rs1D) | (RdE == Rs2D));

  assign fwd_m_a = RegWriteM & (RdM != '0) & (RdM == Rs1E);
  assign fwd_w_a = RegWriteW & (RdW != '0) & (RdW == Rs1E);
  assign fwd_m_b = RegWriteM & (RdM != '0) & (RdM == Rs2E);
  assign fwd_w_b = RegWriteW & (RdW != '0) & (RdW == Rs2E);

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    hold_pipe    = 1'b0;
    run_rules    = 1'b0;
    branch_flush = 1'b0;
    StallF       = 1'b0;
    StallD       = 1'b0;
    StallE       = 1'b0;
    StallM       = 1'b0;
    FlushD       = 1'b0;
    FlushE       = 1'b0;
    FlushW       = 1'b0;
    ForwardAE    = fwd_m_a ? 2'b10 : (fwd_w_a ? 2'b01 : 2'b00);
    ForwardBE    = fwd_m_b ? 2'b10 : (fwd_w_b ? 2'b01 : 2'b00);
    mem_timeout  = 1'b0;

    unique case (state_q)
      RUN: begin
        if (mem_busy) begin
          hold_pipe  = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = WCNT_ENTRY;
        end else begin
          run_rules = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!MemReadyM) begin
          hold_pipe = 1'b1;
          if (wait_cnt_q != WCNT_MAX) wait_cnt_d = wait_cnt_q + WCNT_W'(1);
          if (MEM_TIMEOUT != 0 && wait_cnt_q == WCNT_MAX) state_d = TIMEOUT;
        end else begin
          run_rules  = 1'b1;
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      end
      TIMEOUT: begin
        hold_pipe   = 1'b1;
        mem_timeout = 1'b1;
      end
      default: state_d = RUN;
    endcase

    if (hold_pipe) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (run_rules) begin
      if (PCSrcE) begin
        FlushD       = 1'b1;
        FlushE       = 1'b1;
        branch_flush = 1'b1;
      end else if (load_use) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end

    // Reset forces a clean bubble pattern regardless of inputs.
    if (rst) begin
      StallF       = 1'b0;
      StallD       = 1'b0;
      StallE       = 1'b0;
      StallM       = 1'b0;
      FlushD       = 1'b1;
      FlushE       = 1'b1;
      FlushW       = 1'b0;
      ForwardAE    = 2'b00;
      ForwardBE    = 2'b00;
      mem_timeout  = 1'b0;
      branch_flush = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, flush_events_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      if (StallF)       stall_cycles_q <= stall_cycles_q + CNT_W'(1);
      if (branch_flush) flush_events_q <= flush_events_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic against a behavioural model.
// Perf-counter checks are compiled in when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_ctrl;
  localparam int RW = 5;
  localparam int MT = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic          ResultSrcE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
  logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_timeout;
  logic [1:0]    ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_CNT_EN
  logic [CW-1:0] stall_cycles, flush_events;
`endif

  hazard_ctrl #(.REG_ADDR_W(RW), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // {StallF,StallD,StallE,StallM, FlushD,FlushE,FlushW, mem_timeout, ForwardAE, ForwardBE}
  function automatic logic [11:0] dut_vec();
    return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_timeout, ForwardAE, ForwardBE};
  endfunction

  localparam logic [11:0] V_RESET = 12'h0C0;
  localparam logic [11:0] V_HOLD  = 12'hF20;
  localparam logic [11:0] V_TOUT  = 12'hF30;

  function automatic logic [1:0] ref_fwd(input logic [RW-1:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Behavioural model: counts consecutive unfinished memory cycles instead of tracking FSM states.
  bit m_waiting = 0;
  bit m_dead    = 0;
  int m_busy    = 0;
  int m_stalls  = 0;
  int m_flushes = 0;

  always @(negedge clk) begin
    bit sf, sd, se, sm, fd, fe, fw, to, hold;
    logic [1:0] fa, fb;
    logic [11:0] exp;
    {sf, sd, se, sm, fd, fe, fw, to, hold} = '0;
    fa = 2'b00;
    fb = 2'b00;
    if (rst) begin
      m_waiting = 0; m_dead = 0; m_busy = 0; m_stalls = 0; m_flushes = 0;
      fd = 1; fe = 1;
`ifdef HAZARD_PERF_CNT_EN
      check("perf_stall_rst", 32'(stall_cycles), 32'd0);
      check("perf_flush_rst", 32'(flush_events), 32'd0);
`endif
    end else begin
`ifdef HAZARD_PERF_CNT_EN
      check("perf_stall", 32'(stall_cycles), 32'(m_stalls % (1 << CW)));
      check("perf_flush", 32'(flush_events), 32'(m_flushes % (1 << CW)));
`endif
      fa = ref_fwd(Rs1E);
      fb = ref_fwd(Rs2E);
      if (m_dead) begin
        hold = 1; to = 1;
      end else if (m_waiting ? !MemReadyM : (MemReqM && !MemReadyM)) begin
        hold = 1;
        m_waiting = 1;
        m_busy++;
        if (MT != 0 && m_busy == MT) m_dead = 1;
      end else begin
        m_waiting = 0;
        m_busy = 0;
        if (PCSrcE) begin
          fd = 1; fe = 1;
          m_flushes++;
        end else if (ResultSrcE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D)) begin
          sf = 1; sd = 1; fe = 1;
        end
      end
      if (hold) begin
        sf = 1; sd = 1; se = 1; sm = 1; fw = 1;
      end
      if (sf) m_stalls++;
    end
    exp = {sf, sd, se, sm, fd, fe, fw, to, fa, fb};
    check("model_cycle", 32'(dut_vec()), 32'(exp));
  end

  task automatic clear_inputs();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {ResultSrcE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM} = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5;
    @(negedge clk);
    check("reset_outputs", 32'(dut_vec()), 32'(V_RESET));

    next_cycle(); rst = 1'b0; clear_inputs();
    @(negedge clk);
    check("idle_after_reset", 32'(dut_vec()), 32'd0);

    // Forwarding priority M over W, then W when RdM is x0.
    next_cycle();
    RegWriteM = 1; RdM = 5'd5; Rs1E = 5'd5; RegWriteW = 1; RdW = 5'd5;
    @(negedge clk);
    check("fwdA_from_M", 32'(ForwardAE), 32'b10);
    check("fwdB_rf", 32'(ForwardBE), 32'b00);
    next_cycle(); RdM = 5'd0; Rs2E = 5'd5;
    @(negedge clk);
    check("fwdA_from_W", 32'(ForwardAE), 32'b01);
    check("fwdB_from_W", 32'(ForwardBE), 32'b01);

    // Load-use stall, then no stall with RdE = x0.
    next_cycle(); clear_inputs();
    ResultSrcE = 1; RdE = 5'd7; Rs2D = 5'd7;
    @(negedge clk);
    check("loaduse_sF_sD_sE_fE", 32'({StallF, StallD, StallE, FlushE}), 32'b1101);
    next_cycle(); RdE = 5'd0;
    @(negedge clk);
    check("loaduse_x0", 32'(dut_vec()), 32'd0);

    // Branch overrides load-use.
    next_cycle(); RdE = 5'd7; PCSrcE = 1;
    @(negedge clk);
    check("branch_over_loaduse", 32'({FlushD, FlushE, StallF, StallD}), 32'b1100);

    // Fresh counters: branch, 3-cycle memory wait, branch.
    next_cycle(); clear_inputs(); rst = 1;
    next_cycle(); rst = 0; PCSrcE = 1;
    @(negedge clk);
    check("branch1_flushD", 32'(FlushD), 32'd1);
    next_cycle(); PCSrcE = 0; MemReqM = 1; MemReadyM = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("memwait_hold", 32'(dut_vec()), 32'(V_HOLD));
      if (i < 2) next_cycle();
    end
    next_cycle(); MemReadyM = 1;
    @(negedge clk);
    check("memwait_release", 32'(dut_vec()), 32'd0);
    next_cycle(); clear_inputs(); PCSrcE = 1;
    @(negedge clk);
    check("branch2_flushE", 32'(FlushE), 32'd1);
    next_cycle(); clear_inputs();
    @(negedge clk);
`ifdef HAZARD_PERF_CNT_EN
    check("perf_stall_literal", 32'(stall_cycles), 32'd3);
    check("perf_flush_literal", 32'(flush_events), 32'd2);
`endif

    // Watchdog: four busy cycles, then sticky TIMEOUT, cleared only by reset.
    next_cycle(); MemReqM = 1; MemReadyM = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("pre_timeout_hold", 32'(dut_vec()), 32'(V_HOLD));
      next_cycle();
    end
    @(negedge clk);
    check("timeout_entered", 32'(dut_vec()), 32'(V_TOUT));
    next_cycle(); MemReqM = 0; MemReadyM = 1;
    @(negedge clk);
    check("timeout_sticky", 32'(mem_timeout), 32'd1);
    next_cycle(); rst = 1;
    @(negedge clk);
    check("timeout_rst", 32'(dut_vec()), 32'(V_RESET));
    next_cycle(); rst = 0; clear_inputs();
    @(negedge clk);
    check("run_after_timeout_rst", 32'(dut_vec()), 32'd0);

    // Randomized traffic; the model process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      rst        = ($urandom_range(0, 49) == 0);
      Rs1D       = RW'($urandom_range(0, 3));
      Rs2D       = RW'($urandom_range(0, 3));
      Rs1E       = RW'($urandom_range(0, 3));
      Rs2E       = RW'($urandom_range(0, 3));
      RdE        = RW'($urandom_range(0, 3));
      RdM        = RW'($urandom_range(0, 3));
      RdW        = RW'($urandom_range(0, 3));
      ResultSrcE = ($urandom_range(0, 9) < 3);
      RegWriteM  = ($urandom_range(0, 1) == 1);
      RegWriteW  = ($urandom_range(0, 1) == 1);
      PCSrcE     = ($urandom_range(0, 9) < 2);
      MemReqM    = ($urandom_range(0, 9) < 4);
      MemReadyM  = ($urandom_range(0, 9) < 5);
    end
    next_cycle(); rst = 0; clear_inputs();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
